// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the PC into instruction memory over req/ack and parks each word in a one-entry output register.
// Ack-to-id_valid latency is one cycle; the request is withheld while the output register is full and not being drained.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [3:0]           HALT_OP  = 4'hB
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [3:0]          id_opcode,
  output logic [ADDR_W-1:0]   id_pc,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halted
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              fetch_acc;
  logic              xfer;
  logic              fetch_is_halt;

  assign slot_free     = !id_valid || id_ready;
  assign imem_req      = (state == S_FETCH) && slot_free && !redirect;
  assign imem_addr     = pc;
  assign fetch_acc     = imem_req && imem_ack;
  assign xfer          = id_valid && id_ready;
  assign fetch_is_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);
  assign id_opcode     = id_instr[INSTR_W-1 -: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
      halted   <= 1'b0;
    end else if (redirect) begin
      // Request is suppressed this cycle, so a stray ack can never load the register.
      state    <= S_FETCH;
      pc       <= redirect_pc;
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (fetch_acc) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc    <= pc;
      pc       <= pc + ADDR_W'(1);
      if (fetch_is_halt) begin
        state  <= S_HALT;
        halted <= 1'b1;
      end
    end else if (xfer) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: table of per-cycle vectors against a behavioural imem, plus hand sequences for wait states and a wrapping reset PC.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        id_valid, id_ready = 1'b1;
  logic [15:0] id_instr;
  logic [3:0]  id_opcode;
  logic [7:0]  id_pc;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halted;
  logic        ack_force = 1'b0;
  logic        mem_wait = 1'b0;

  // second instance (RESET_PC = FE)
  logic        rst_n_fe = 1'b0;
  logic        imem_req_fe, imem_ack_fe;
  logic [7:0]  imem_addr_fe;
  logic [15:0] imem_rdata_fe;
  logic        id_valid_fe;
  logic [15:0] id_instr_fe;
  logic [3:0]  id_opcode_fe;
  logic [7:0]  id_pc_fe;
  logic        halted_fe;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return (a == 8'h05) ? 16'hB000 : {8'h10, a};
  endfunction

  assign imem_ack      = ack_force || (!mem_wait && imem_req);
  assign imem_rdata    = mem_word(imem_addr);
  assign imem_ack_fe   = imem_req_fe;
  assign imem_rdata_fe = {8'h10, imem_addr_fe};

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_opcode(id_opcode), .id_pc(id_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  instr_fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .rst_n(rst_n_fe),
    .imem_req(imem_req_fe), .imem_addr(imem_addr_fe), .imem_ack(imem_ack_fe), .imem_rdata(imem_rdata_fe),
    .id_valid(id_valid_fe), .id_ready(1'b1), .id_instr(id_instr_fe), .id_opcode(id_opcode_fe), .id_pc(id_pc_fe),
    .redirect(1'b0), .redirect_pc(8'h00), .halted(halted_fe)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int req6_cnt = 0;

  always @(posedge clk)
    if (rst_n && imem_req && imem_addr == 8'h06) req6_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst_n;
    logic        redirect;
    logic [7:0]  rpc;
    logic        rdy;
    logic        ackf;
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        halted;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic rd, input logic [7:0] rpc, input logic rdy,
                              input logic ackf, input logic req, input logic [7:0] addr, input logic valid,
                              input logic [7:0] pc, input logic [15:0] instr, input logic hlt);
    vec_t v;
    v.rst_n = rn; v.redirect = rd; v.rpc = rpc; v.rdy = rdy; v.ackf = ackf;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr; v.halted = hlt;
    return v;
  endfunction

  vec_t vt[22];

  initial begin
    //         rn rd rpc    rdy ackf | req addr   vld pc     instr     hlt
    vt[0]  = mk(1, 0, 8'h00, 1, 0,    1, 8'h00, 0, 8'h00, 16'h0000, 0);
    vt[1]  = mk(1, 0, 8'h00, 1, 0,    1, 8'h01, 1, 8'h00, 16'h1000, 0);
    vt[2]  = mk(1, 0, 8'h00, 1, 0,    1, 8'h02, 1, 8'h01, 16'h1001, 0);
    vt[3]  = mk(1, 0, 8'h00, 0, 0,    0, 8'h03, 1, 8'h02, 16'h1002, 0);
    vt[4]  = mk(1, 0, 8'h00, 0, 0,    0, 8'h03, 1, 8'h02, 16'h1002, 0);
    vt[5]  = mk(1, 0, 8'h00, 0, 0,    0, 8'h03, 1, 8'h02, 16'h1002, 0);
    vt[6]  = mk(1, 0, 8'h00, 1, 0,    1, 8'h03, 1, 8'h02, 16'h1002, 0);
    vt[7]  = mk(1, 0, 8'h00, 1, 0,    1, 8'h04, 1, 8'h03, 16'h1003, 0);
    vt[8]  = mk(1, 0, 8'h00, 1, 0,    1, 8'h05, 1, 8'h04, 16'h1004, 0);
    vt[9]  = mk(1, 0, 8'h00, 1, 0,    0, 8'h06, 1, 8'h05, 16'hB000, 1);
    vt[10] = mk(1, 0, 8'h00, 1, 0,    0, 8'h06, 0, 8'h05, 16'hB000, 1);
    vt[11] = mk(1, 1, 8'h40, 1, 1,    0, 8'h06, 0, 8'h05, 16'hB000, 1);
    vt[12] = mk(1, 0, 8'h00, 0, 0,    1, 8'h40, 0, 8'h05, 16'hB000, 0);
    vt[13] = mk(1, 1, 8'h20, 0, 1,    0, 8'h41, 1, 8'h40, 16'h1040, 0);
    vt[14] = mk(1, 0, 8'h00, 1, 0,    1, 8'h20, 0, 8'h40, 16'h1040, 0);
    vt[15] = mk(1, 1, 8'h04, 0, 0,    0, 8'h21, 1, 8'h20, 16'h1020, 0);
    vt[16] = mk(1, 0, 8'h00, 1, 0,    1, 8'h04, 0, 8'h20, 16'h1020, 0);
    vt[17] = mk(1, 0, 8'h00, 1, 0,    1, 8'h05, 1, 8'h04, 16'h1004, 0);
    vt[18] = mk(1, 0, 8'h00, 0, 0,    0, 8'h06, 1, 8'h05, 16'hB000, 1);
    vt[19] = mk(0, 0, 8'h00, 0, 0,    0, 8'h06, 1, 8'h05, 16'hB000, 1);
    vt[20] = mk(1, 0, 8'h00, 0, 0,    1, 8'h00, 0, 8'h00, 16'h0000, 0);
    vt[21] = mk(1, 0, 8'h00, 1, 0,    1, 8'h01, 1, 8'h00, 16'h1000, 0);

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_halted",   halted,   1'b0);
    chk("rst_id_pc",    id_pc,    8'h00);
    chk("rst_id_instr", id_instr, 16'h0000);
    chk("rst_imem_addr", imem_addr, 8'h00);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst_n       = vt[i].rst_n;
      redirect    = vt[i].redirect;
      redirect_pc = vt[i].rpc;
      id_ready    = vt[i].rdy;
      ack_force   = vt[i].ackf;
      #1;
      chk($sformatf("v%0d_imem_req", i),  imem_req,  vt[i].req);
      chk($sformatf("v%0d_imem_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d_id_valid", i),  id_valid,  vt[i].valid);
      chk($sformatf("v%0d_id_pc", i),     id_pc,     vt[i].pc);
      chk($sformatf("v%0d_id_instr", i),  id_instr,  vt[i].instr);
      chk($sformatf("v%0d_id_opcode", i), id_opcode, vt[i].instr[15:12]);
      chk($sformatf("v%0d_halted", i),    halted,    vt[i].halted);
    end
    chk("addr6_never_requested", req6_cnt, 0);

    // wait-state memory: request and address held until ack
    @(negedge clk);
    rst_n = 1'b1; redirect = 1'b0; id_ready = 1'b1; mem_wait = 1'b1; ack_force = 1'b0;
    #1;
    chk("ws0_req", imem_req, 1'b1);
    chk("ws0_addr", imem_addr, 8'h02);
    chk("ws0_id_pc", id_pc, 8'h01);
    @(negedge clk); #1;
    chk("ws1_req", imem_req, 1'b1);
    chk("ws1_addr", imem_addr, 8'h02);
    chk("ws1_id_valid", id_valid, 1'b0);
    @(negedge clk);
    ack_force = 1'b1;
    #1;
    chk("ws2_addr", imem_addr, 8'h02);
    @(negedge clk);
    ack_force = 1'b0;
    #1;
    chk("ws3_id_valid", id_valid, 1'b1);
    chk("ws3_id_pc", id_pc, 8'h02);
    chk("ws3_id_instr", id_instr, 16'h1002);
    chk("ws3_addr", imem_addr, 8'h03);
    mem_wait = 1'b0;

    // PC wrap from RESET_PC = FE
    begin
      logic [7:0] exp_seq [4];
      int got;
      exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
      got = 0;
      @(negedge clk);
      rst_n_fe = 1'b1;
      #1;
      chk("fe_reset_addr", imem_addr_fe, 8'hFE);
      for (int c = 0; c < 10 && got < 4; c++) begin
        @(negedge clk); #1;
        if (id_valid_fe) begin
          chk($sformatf("fe_seq%0d_id_pc", got), id_pc_fe, exp_seq[got]);
          chk($sformatf("fe_seq%0d_instr", got), id_instr_fe, {8'h10, exp_seq[got]});
          got++;
        end
      end
      chk("fe_seq_count", got, 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
